// File: rtl/libv_deque_pkg.sv
// Shared types for the libv deque: command encodings and index-arithmetic selects.
package libv_deque_pkg;

  typedef enum logic [2:0] {
    PushFront = 3'd0,
    PopFront  = 3'd1,
    PushBack  = 3'd2,
    PopBack   = 3'd3,
    Flush     = 3'd4
  } mc_cmd_t;

  typedef enum logic [1:0] {
    IdxInc = 2'd0,
    IdxDec = 2'd1,
    IdxAdd = 2'd2
  } idx_op_t;

  function automatic logic is_push(mc_cmd_t op);
    return (op == PushFront) || (op == PushBack);
  endfunction

  function automatic logic is_pop(mc_cmd_t op);
    return (op == PopFront) || (op == PopBack);
  endfunction

endpackage

// File: rtl/libv_deque_mc_if.sv
// Command/response/status bundle between a libv stage and the multi-command deque.
interface libv_deque_mc_if
  import libv_deque_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 8
);
  logic                     cmd_vld;
  mc_cmd_t                  cmd_op;
  logic [W-1:0]             cmd_push_data;
  logic                     rsp_vld;
  logic                     rsp_err;
  logic [W-1:0]             rsp_data;
  logic                     empty;
  logic                     full;
  logic                     almost_full;
  logic [$clog2(N+1)-1:0]   count;

  modport master (
    output cmd_vld, cmd_op, cmd_push_data,
    input  rsp_vld, rsp_err, rsp_data, empty, full, almost_full, count
  );

  modport slave (
    input  cmd_vld, cmd_op, cmd_push_data,
    output rsp_vld, rsp_err, rsp_data, empty, full, almost_full, count
  );
endinterface

// File: rtl/libv_mod_ctr_idx.sv
// Combinational modulo-N index step: increment, decrement, or add an offset in 0..N.
module libv_mod_ctr_idx
  import libv_deque_pkg::*;
#(
  parameter int N = 8
) (
  input  idx_op_t                  op,
  input  logic [$clog2(N)-1:0]     idx,
  input  logic [$clog2(N+1)-1:0]   off,
  output logic [$clog2(N)-1:0]     res
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N+1);

  // idx + off never exceeds 2N-1, so one conditional subtract is enough
  logic [CW:0] sum;

  always_comb begin
    res = idx;
    sum = '0;
    case (op)
      IdxInc: res = (idx == IW'(N-1)) ? '0 : idx + IW'(1);
      IdxDec: res = (idx == '0) ? IW'(N-1) : idx - IW'(1);
      IdxAdd: begin
        sum = (CW+1)'(idx) + (CW+1)'(off);
        res = (sum >= (CW+1)'(N)) ? IW'(sum - (CW+1)'(N)) : IW'(sum);
      end
      default: res = idx;
    endcase
  end
endmodule

// File: rtl/libv_deque_mc.sv
// Double-ended queue with one push/pop/flush command per cycle and a registered response.
module libv_deque_mc
  import libv_deque_pkg::*;
#(
  parameter int W         = 32,
  parameter int N         = 8,
  parameter int AF_THRESH = N-1
) (
  input logic             clk,
  input logic             rst,
  libv_deque_mc_if.slave  bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N+1);

  logic [W-1:0]  mem [N];
  logic [IW-1:0] f_q, f_nxt, f_step, back_addr, wr_addr, rd_addr;
  logic [CW-1:0] c_q, c_nxt, back_off;
  idx_op_t       f_op;
  logic          we, rd_en, rej, is_full;

  logic          rsp_vld_q, rsp_err_q, empty_q, full_q, af_q;
  logic [W-1:0]  rsp_data_q;

  assign is_full = (c_q == CW'(N));

  always_comb begin
    f_op     = (bus.cmd_op == PushFront) ? IdxDec : IdxInc;
    back_off = (bus.cmd_op == PopBack && c_q != '0) ? c_q - CW'(1) : c_q;
  end

  libv_mod_ctr_idx #(.N(N)) u_front (
    .op  (f_op),
    .idx (f_q),
    .off (c_q),
    .res (f_step)
  );

  // Back slot: (f+c) for push, (f+c-1) for pop
  libv_mod_ctr_idx #(.N(N)) u_back (
    .op  (IdxAdd),
    .idx (f_q),
    .off (back_off),
    .res (back_addr)
  );

  always_comb begin
    f_nxt   = f_q;
    c_nxt   = c_q;
    we      = 1'b0;
    rd_en   = 1'b0;
    wr_addr = f_q;
    rd_addr = f_q;
    rej     = bus.cmd_vld && ((is_push(bus.cmd_op) && is_full) ||
                              (is_pop(bus.cmd_op) && c_q == '0));
    if (bus.cmd_vld && !rej) begin
      case (bus.cmd_op)
        PushFront: begin
          f_nxt   = f_step;
          wr_addr = f_step;
          we      = 1'b1;
          c_nxt   = c_q + CW'(1);
        end
        PushBack: begin
          wr_addr = back_addr;
          we      = 1'b1;
          c_nxt   = c_q + CW'(1);
        end
        PopFront: begin
          rd_addr = f_q;
          rd_en   = 1'b1;
          f_nxt   = f_step;
          c_nxt   = c_q - CW'(1);
        end
        PopBack: begin
          rd_addr = back_addr;
          rd_en   = 1'b1;
          c_nxt   = c_q - CW'(1);
        end
        Flush: begin
          f_nxt = '0;
          c_nxt = '0;
        end
        default: ;
      endcase
    end
  end

  // Registered state, response and status (status follows next-state occupancy)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_q        <= '0;
      c_q        <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      af_q       <= 1'b0;
    end else begin
      f_q        <= f_nxt;
      c_q        <= c_nxt;
      rsp_vld_q  <= bus.cmd_vld;
      rsp_err_q  <= rej;
      rsp_data_q <= rd_en ? mem[rd_addr] : '0;
      empty_q    <= (c_nxt == '0);
      full_q     <= (c_nxt == CW'(N));
      af_q       <= (c_nxt >= CW'(AF_THRESH));
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= bus.cmd_push_data;
  end

  assign bus.rsp_vld     = rsp_vld_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.empty       = empty_q;
  assign bus.full        = full_q;
  assign bus.almost_full = af_q;
  assign bus.count       = c_q;
endmodule
